// File: rtl/gtfmac_bs_pkg.sv
// Shared types and default constants for the GTFMAC RX bitslip corrector.
// Contents:
//   bs_state_e   per-lane FSM state encoding
//   DEF_*        default parameter values used by the top and lane modules
package gtfmac_bs_pkg;

  typedef enum logic [2:0] {
    ST_SYNC    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_CORRECT = 3'd2,
    ST_ACK     = 3'd3,
    ST_RESYNC  = 3'd4,
    ST_DONE    = 3'd5,
    ST_ERROR   = 3'd6
  } bs_state_e;

  localparam int DEF_NUM_CH       = 4;
  localparam int DEF_CNT_W        = 7;
  localparam int DEF_LOCK_FILTER  = 8;
  localparam int DEF_RDY_TIMEOUT  = 1024;
  localparam int DEF_SEQ_SYNC_LEN = 8;
  localparam int DEF_AUTO_CORRECT = 0;

endpackage

// File: rtl/gtfmac_hwchk_bitslip_mc_if.sv
// GTFMAC-side bitslip handshake bundle, one bit per lane.
//   master : GTFMAC/PMA side, drives rx_block_lock, rx_bitslip, rx_slip_pma_rdy
//   slave  : corrector side, drives bs_slip_pma, bs_slip_one_ui, bs_gb_seq_sync, bs_disable_bitslip
interface gtfmac_hwchk_bitslip_mc_if
  import gtfmac_bs_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH
);

  logic [NUM_CH-1:0] rx_block_lock;
  logic [NUM_CH-1:0] rx_bitslip;
  logic [NUM_CH-1:0] rx_slip_pma_rdy;
  logic [NUM_CH-1:0] bs_slip_pma;
  logic [NUM_CH-1:0] bs_slip_one_ui;
  logic [NUM_CH-1:0] bs_gb_seq_sync;
  logic [NUM_CH-1:0] bs_disable_bitslip;

  modport master (
    output rx_block_lock, rx_bitslip, rx_slip_pma_rdy,
    input  bs_slip_pma, bs_slip_one_ui, bs_gb_seq_sync, bs_disable_bitslip
  );

  modport slave (
    input  rx_block_lock, rx_bitslip, rx_slip_pma_rdy,
    output bs_slip_pma, bs_slip_one_ui, bs_gb_seq_sync, bs_disable_bitslip
  );

endinterface

// File: rtl/gtfmac_bs_lane_fsm.sv
// One lane of the bitslip corrector: slip counter, lock filter, replay FSM,
// PMA handshake timeout and gearbox resync pulse.
// Ports:
//   rx_clk, reset (active-low, async assert)
//   correct, rate_25g          synced correction request, 25G lane select
//   block_lock, bitslip, slip_pma_rdy   raw GTFMAC/PMA inputs
//   slip_pma, slip_one_ui, seq_sync, disable_bs   lane outputs
//   cnt, issued, locked, busy, done, excessive, timeout   lane status
//   relock_cnt                 only when GTFMAC_BS_RELOCK_EN is defined
// Build option: GTFMAC_BS_RELOCK_EN lets DONE fall back to SYNC on loss of lock.
//
// state   | meaning
// SYNC    | counting GTFMAC slips, waiting for filtered lock
// WAIT    | locked, bitslip frozen, waiting for correct request
// CORRECT | replaying outstanding slips
// ACK     | 2-UI PMA slip in flight, handshaking with rdy
// RESYNC  | 2-cycle gap then gearbox seq-sync pulse
// DONE    | lane corrected (or 25G lane locked)
// ERROR   | excessive slips or PMA handshake timeout
module gtfmac_bs_lane_fsm
  import gtfmac_bs_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int LOCK_FILTER  = DEF_LOCK_FILTER,
  parameter int RDY_TIMEOUT  = DEF_RDY_TIMEOUT,
  parameter int SEQ_SYNC_LEN = DEF_SEQ_SYNC_LEN,
  parameter int AUTO_CORRECT = DEF_AUTO_CORRECT
) (
  input  logic             rx_clk,
  input  logic             reset,
  input  logic             correct,
  input  logic             rate_25g,
  input  logic             block_lock,
  input  logic             bitslip,
  input  logic             slip_pma_rdy,
  output logic             slip_pma,
  output logic             slip_one_ui,
  output logic             seq_sync,
  output logic             disable_bs,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] issued,
  output logic             locked,
  output logic             busy,
  output logic             done,
  output logic             excessive,
  output logic             timeout
`ifdef GTFMAC_BS_RELOCK_EN
  ,
  output logic [7:0]       relock_cnt
`endif
);

  localparam int LF_W = $clog2(LOCK_FILTER + 1);
  localparam int TO_W = $clog2(RDY_TIMEOUT + 1);
  localparam int RS_W = $clog2(SEQ_SYNC_LEN + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  bs_state_e        state_q, state_d;
  logic [2:0]       slip_pipe_q, slip_pipe_d;
  logic [LF_W-1:0]  filt_q, filt_d;
  logic [TO_W-1:0]  tmr_q, tmr_d;
  logic [RS_W-1:0]  rs_q, rs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, issued_q, issued_d;
  logic             slip_pma_q, slip_pma_d;
  logic             one_ui_q, one_ui_d;
  logic             seq_sync_q, seq_sync_d;
  logic             disable_q, disable_d;
  logic             excessive_q, excessive_d;
  logic             timeout_q, timeout_d;
`ifdef GTFMAC_BS_RELOCK_EN
  logic [7:0]       relock_q, relock_d;
`endif

  logic             slip_edge;
  logic             locked_w;
  logic             slip_err;
  logic [CNT_W-1:0] delta;

  // Two register stages on rx_bitslip, third stage only for edge detect.
  assign slip_edge = slip_pipe_q[1] & ~slip_pipe_q[2];
  assign locked_w  = (filt_q == '0);
  // Outstanding slips; wraps modulo 2**CNT_W by construction.
  assign delta     = cnt_q - issued_q;

  always_comb begin
    slip_pipe_d = {slip_pipe_q[1:0], bitslip};
    filt_d      = filt_q;
    if (!block_lock) begin
      filt_d = LF_W'(LOCK_FILTER);
    end else if (filt_q != '0) begin
      filt_d = filt_q - LF_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    issued_d    = issued_q;
    slip_pma_d  = slip_pma_q;
    one_ui_d    = one_ui_q;
    seq_sync_d  = 1'b0;
    disable_d   = disable_q;
    excessive_d = excessive_q;
    timeout_d   = timeout_q;
    tmr_d       = tmr_q;
    rs_d        = rs_q;
    slip_err    = 1'b0;
`ifdef GTFMAC_BS_RELOCK_EN
    relock_d    = relock_q;
`endif

    case (state_q)
      ST_SYNC: begin
        disable_d = 1'b0;
        if (slip_edge) begin
          if (cnt_q == CNT_MAX) begin
            slip_err    = 1'b1;
            excessive_d = 1'b1;
            disable_d   = 1'b1;
            state_d     = ST_ERROR;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        // A slip landing with lock is counted above before leaving SYNC.
        if (locked_w && !slip_err) begin
          if (rate_25g) begin
            state_d = ST_DONE;
          end else begin
            disable_d = 1'b1;
            state_d   = (AUTO_CORRECT != 0) ? ST_CORRECT : ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (correct) state_d = ST_CORRECT;
      end

      ST_CORRECT: begin
        if (delta >= CNT_W'(2)) begin
          slip_pma_d = 1'b1;
          issued_d   = issued_q + CNT_W'(2);
          tmr_d      = TO_W'(RDY_TIMEOUT);
          state_d    = ST_ACK;
        end else if (delta == CNT_W'(1)) begin
          one_ui_d = 1'b1;
          issued_d = issued_q + CNT_W'(1);
        end else begin
          rs_d    = RS_W'(SEQ_SYNC_LEN + 1);
          state_d = ST_RESYNC;
        end
      end

      // Two phases, each with its own timeout window: rdy falling while the
      // request is up, then rdy rising after the request is dropped.
      ST_ACK: begin
        if (slip_pma_q && !slip_pma_rdy) begin
          slip_pma_d = 1'b0;
          tmr_d      = TO_W'(RDY_TIMEOUT);
        end else if (!slip_pma_q && slip_pma_rdy) begin
          state_d = ST_CORRECT;
        end else if (tmr_q == '0) begin
          slip_pma_d = 1'b0;
          timeout_d  = 1'b1;
          state_d    = ST_ERROR;
        end else begin
          tmr_d = tmr_q - TO_W'(1);
        end
      end

      ST_RESYNC: begin
        if (rs_q == '0) begin
          state_d = ST_DONE;
        end else begin
          rs_d       = rs_q - RS_W'(1);
          seq_sync_d = (rs_q <= RS_W'(SEQ_SYNC_LEN));
        end
      end

      ST_DONE: begin
`ifdef GTFMAC_BS_RELOCK_EN
        if (!locked_w) begin
          cnt_d    = '0;
          issued_d = '0;
          one_ui_d = 1'b0;
          state_d  = ST_SYNC;
          if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
        end
`endif
      end

      ST_ERROR: begin
        disable_d = 1'b1;
      end

      default: state_d = ST_SYNC;
    endcase
  end

  always_ff @(posedge rx_clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_SYNC;
      slip_pipe_q <= '0;
      filt_q      <= LF_W'(LOCK_FILTER);
      tmr_q       <= '0;
      rs_q        <= '0;
      cnt_q       <= '0;
      issued_q    <= '0;
      slip_pma_q  <= 1'b0;
      one_ui_q    <= 1'b0;
      seq_sync_q  <= 1'b0;
      disable_q   <= 1'b1;
      excessive_q <= 1'b0;
      timeout_q   <= 1'b0;
`ifdef GTFMAC_BS_RELOCK_EN
      relock_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      slip_pipe_q <= slip_pipe_d;
      filt_q      <= filt_d;
      tmr_q       <= tmr_d;
      rs_q        <= rs_d;
      cnt_q       <= cnt_d;
      issued_q    <= issued_d;
      slip_pma_q  <= slip_pma_d;
      one_ui_q    <= one_ui_d;
      seq_sync_q  <= seq_sync_d;
      disable_q   <= disable_d;
      excessive_q <= excessive_d;
      timeout_q   <= timeout_d;
`ifdef GTFMAC_BS_RELOCK_EN
      relock_q    <= relock_d;
`endif
    end
  end

  assign slip_pma    = slip_pma_q;
  assign slip_one_ui = one_ui_q;
  assign seq_sync    = seq_sync_q;
  assign disable_bs  = disable_q;
  assign cnt         = cnt_q;
  assign issued      = issued_q;
  assign locked      = locked_w;
  assign busy        = (state_q == ST_CORRECT) || (state_q == ST_ACK) || (state_q == ST_RESYNC);
  assign done        = (state_q == ST_DONE) || (state_q == ST_ERROR);
  assign excessive   = excessive_q;
  assign timeout     = timeout_q;
`ifdef GTFMAC_BS_RELOCK_EN
  assign relock_cnt  = relock_q;
`endif

endmodule

// File: rtl/gtfmac_hwchk_bitslip_mc.sv
// N-channel GTFMAC RX bitslip corrector top. One independent lane FSM per
// channel, all in the rx_clk domain.
// Ports:
//   rx_clk, reset (active-low, async assert, synchronous release)
//   ctl_correct_bitslip, ctl_disable_bitslip   async levels, 2-flop synced
//   ctl_gb_seq_sync                            ORed straight into bs_gb_seq_sync
//   ctl_rx_data_rate                           1 = 25G lane, no correction
//   gt (slave modport)                         GTFMAC lock/slip/handshake bundle
//   stat_*                                     per-lane status, counters packed CNT_W per lane
//   stat_relock_cnt                            only when GTFMAC_BS_RELOCK_EN is defined
module gtfmac_hwchk_bitslip_mc
  import gtfmac_bs_pkg::*;
#(
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int LOCK_FILTER  = DEF_LOCK_FILTER,
  parameter int RDY_TIMEOUT  = DEF_RDY_TIMEOUT,
  parameter int SEQ_SYNC_LEN = DEF_SEQ_SYNC_LEN,
  parameter int AUTO_CORRECT = DEF_AUTO_CORRECT
) (
  input  logic                    rx_clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       ctl_correct_bitslip,
  input  logic [NUM_CH-1:0]       ctl_disable_bitslip,
  input  logic [NUM_CH-1:0]       ctl_gb_seq_sync,
  input  logic [NUM_CH-1:0]       ctl_rx_data_rate,
  gtfmac_hwchk_bitslip_mc_if.slave gt,
  output logic [NUM_CH*CNT_W-1:0] stat_bitslip_cnt,
  output logic [NUM_CH*CNT_W-1:0] stat_bitslip_issued,
  output logic [NUM_CH-1:0]       stat_locked,
  output logic [NUM_CH-1:0]       stat_busy,
  output logic [NUM_CH-1:0]       stat_done,
  output logic [NUM_CH-1:0]       stat_excessive,
  output logic [NUM_CH-1:0]       stat_timeout
`ifdef GTFMAC_BS_RELOCK_EN
  ,
  output logic [NUM_CH*8-1:0]     stat_relock_cnt
`endif
);

  logic [1:0]        rst_sync_q, rst_sync_d;
  logic              rst_b_s;
  logic [NUM_CH-1:0] corr_meta_q, corr_meta_d, corr_sync_q, corr_sync_d;
  logic [NUM_CH-1:0] dis_meta_q, dis_meta_d, dis_sync_q, dis_sync_d;
  logic [NUM_CH-1:0] lane_seq_sync, lane_disable;

  always_comb begin
    rst_sync_d  = {rst_sync_q[0], 1'b1};
    corr_meta_d = ctl_correct_bitslip;
    corr_sync_d = corr_meta_q;
    dis_meta_d  = ctl_disable_bitslip;
    dis_sync_d  = dis_meta_q;
  end

  // Assertion reaches every lane flop immediately; release lines up to a clock edge.
  always_ff @(posedge rx_clk or negedge reset) begin
    if (!reset) rst_sync_q <= '0;
    else        rst_sync_q <= rst_sync_d;
  end

  assign rst_b_s = rst_sync_q[1];

  always_ff @(posedge rx_clk or negedge rst_b_s) begin
    if (!rst_b_s) begin
      corr_meta_q <= '0;
      corr_sync_q <= '0;
      dis_meta_q  <= '0;
      dis_sync_q  <= '0;
    end else begin
      corr_meta_q <= corr_meta_d;
      corr_sync_q <= corr_sync_d;
      dis_meta_q  <= dis_meta_d;
      dis_sync_q  <= dis_sync_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    gtfmac_bs_lane_fsm #(
      .CNT_W       (CNT_W),
      .LOCK_FILTER (LOCK_FILTER),
      .RDY_TIMEOUT (RDY_TIMEOUT),
      .SEQ_SYNC_LEN(SEQ_SYNC_LEN),
      .AUTO_CORRECT(AUTO_CORRECT)
    ) u_lane (
      .rx_clk      (rx_clk),
      .reset       (rst_b_s),
      .correct     (corr_sync_q[i]),
      .rate_25g    (ctl_rx_data_rate[i]),
      .block_lock  (gt.rx_block_lock[i]),
      .bitslip     (gt.rx_bitslip[i]),
      .slip_pma_rdy(gt.rx_slip_pma_rdy[i]),
      .slip_pma    (gt.bs_slip_pma[i]),
      .slip_one_ui (gt.bs_slip_one_ui[i]),
      .seq_sync    (lane_seq_sync[i]),
      .disable_bs  (lane_disable[i]),
      .cnt         (stat_bitslip_cnt[i*CNT_W +: CNT_W]),
      .issued      (stat_bitslip_issued[i*CNT_W +: CNT_W]),
      .locked      (stat_locked[i]),
      .busy        (stat_busy[i]),
      .done        (stat_done[i]),
      .excessive   (stat_excessive[i]),
      .timeout     (stat_timeout[i])
`ifdef GTFMAC_BS_RELOCK_EN
      ,
      .relock_cnt  (stat_relock_cnt[i*8 +: 8])
`endif
    );
  end

  assign gt.bs_gb_seq_sync     = lane_seq_sync | ctl_gb_seq_sync;
  assign gt.bs_disable_bitslip = lane_disable | dis_sync_q;

endmodule
